// File: rtl/i2c_addr_xlate_table.sv
// I2C address translator with a runtime-programmable mapping table.
// Sits between an upstream transaction requester and the downstream I2C
// master. It maps logical 7-bit addresses to physical ones, optionally
// rejects unmapped addresses, holds off launch while the master is busy,
// and aborts a transaction that exceeds a cycle budget.
module i2c_addr_xlate_table #(
  parameter int NUM_ENTRIES    = 4,
  parameter int DATA_W         = 8,
  parameter bit PASS_UNMAPPED  = 1'b0,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_valid,
  input  logic [6:0]        cfg_logical,
  input  logic [6:0]        cfg_physical,
  input  logic              up_start,
  input  logic [6:0]        up_addr,
  input  logic              up_rw,
  input  logic [DATA_W-1:0] up_wr_data,
  output logic [DATA_W-1:0] up_rd_data,
  output logic              up_busy,
  output logic              up_done,
  output logic              up_ack_error,
  output logic              up_map_error,
  output logic              up_timeout,
  output logic              dn_start,
  output logic [6:0]        dn_addr,
  output logic              dn_rw,
  output logic [DATA_W-1:0] dn_wr_data,
  input  logic [DATA_W-1:0] dn_rd_data,
  input  logic              dn_busy,
  input  logic              dn_done,
  input  logic              dn_ack_error
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: expiry is detected on
  // the last permitted cycle rather than one cycle late.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  tmo_cnt_reg;
  logic              tmo_expire;

  logic              ent_valid_reg    [NUM_ENTRIES];
  logic [6:0]        ent_logical_reg  [NUM_ENTRIES];
  logic [6:0]        ent_physical_reg [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] ent_match;

  logic              lookup_hit;
  logic [6:0]        lookup_phys;

  logic [DATA_W-1:0] up_rd_data_reg;
  logic              up_ack_error_reg;
  logic              up_map_error_reg;
  logic              up_timeout_reg;
  logic [6:0]        dn_addr_reg;
  logic              dn_rw_reg;
  logic [DATA_W-1:0] dn_wr_data_reg;

  // One storage slot per entry; out-of-range indices match no slot and are dropped.
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      // Entry write port, usable in every FSM state
      always_ff @(posedge clk) begin
        if (rst) begin
          ent_valid_reg[gi]    <= 1'b0;
          ent_logical_reg[gi]  <= 7'd0;
          ent_physical_reg[gi] <= 7'd0;
        end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
          ent_valid_reg[gi]    <= cfg_valid;
          ent_logical_reg[gi]  <= cfg_logical;
          ent_physical_reg[gi] <= cfg_physical;
        end
      end

      assign ent_match[gi] = ent_valid_reg[gi] && (ent_logical_reg[gi] == up_addr);
    end
  endgenerate

  // Priority select: scanning from the top lets the lowest matching index win
  always_comb begin
    lookup_hit  = |ent_match;
    lookup_phys = 7'd0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_match[i]) begin
        lookup_phys = ent_physical_reg[i];
      end
    end
  end

  assign tmo_expire = (TIMEOUT_CYCLES > 0) && (tmo_cnt_reg == CNT_LAST);

  // Transaction sequencer: accept, launch, wait for completion, report
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      tmo_cnt_reg      <= '0;
      up_rd_data_reg   <= '0;
      up_ack_error_reg <= 1'b0;
      up_map_error_reg <= 1'b0;
      up_timeout_reg   <= 1'b0;
      dn_addr_reg      <= 7'd0;
      dn_rw_reg        <= 1'b0;
      dn_wr_data_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (up_start) begin
            dn_rw_reg        <= up_rw;
            dn_wr_data_reg   <= up_wr_data;
            up_map_error_reg <= 1'b0;
            up_timeout_reg   <= 1'b0;
            up_ack_error_reg <= 1'b0;
            up_rd_data_reg   <= '0;
            tmo_cnt_reg      <= '0;
            if (lookup_hit) begin
              dn_addr_reg <= lookup_phys;
              state_reg   <= ST_LAUNCH;
            end else if (PASS_UNMAPPED) begin
              dn_addr_reg <= up_addr;
              state_reg   <= ST_LAUNCH;
            end else begin
              dn_addr_reg      <= 7'd0;
              up_map_error_reg <= 1'b1;
              state_reg        <= ST_DONE;
            end
          end
        end
        ST_LAUNCH: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (tmo_expire) begin
            up_timeout_reg   <= 1'b1;
            up_ack_error_reg <= 1'b1;
            up_rd_data_reg   <= '0;
            state_reg        <= ST_DONE;
          end else if (!dn_busy) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          // A completion on the expiry cycle takes precedence over the abort
          if (dn_done) begin
            up_rd_data_reg   <= dn_rw_reg ? dn_rd_data : '0;
            up_ack_error_reg <= dn_ack_error;
            state_reg        <= ST_DONE;
          end else if (tmo_expire) begin
            up_timeout_reg   <= 1'b1;
            up_ack_error_reg <= 1'b1;
            up_rd_data_reg   <= '0;
            state_reg        <= ST_DONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Launch pulse is decoded from state; suppressed on the expiry cycle so an
  // aborted transaction never leaves an orphaned launch behind.
  assign dn_start     = (state_reg == ST_LAUNCH) && !dn_busy && !tmo_expire;
  assign up_busy      = (state_reg != ST_IDLE);
  assign up_done      = (state_reg == ST_DONE);
  assign up_rd_data   = up_rd_data_reg;
  assign up_ack_error = up_ack_error_reg;
  assign up_map_error = up_map_error_reg;
  assign up_timeout   = up_timeout_reg;
  assign dn_addr      = dn_addr_reg;
  assign dn_rw        = dn_rw_reg;
  assign dn_wr_data   = dn_wr_data_reg;

endmodule

// File: tb/tb_i2c_addr_xlate_table.sv
// Self-checking bench for i2c_addr_xlate_table. Two instances share all
// inputs: u0 rejects unmapped addresses, u1 forwards them. A table-level
// reference model predicts every transaction's timing and results.
module tb_i2c_addr_xlate_table;

  localparam int NE = 4;
  localparam int DW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic          cfg_valid = 1'b0;
  logic [6:0]    cfg_logical = '0;
  logic [6:0]    cfg_physical = '0;
  logic          up_start = 1'b0;
  logic [6:0]    up_addr = '0;
  logic          up_rw = 1'b0;
  logic [DW-1:0] up_wr_data = '0;
  logic [DW-1:0] dn_rd_data = '0;
  logic          dn_busy = 1'b0;
  logic          dn_done = 1'b0;
  logic          dn_ack_error = 1'b0;

  logic [DW-1:0] u0_rd, u1_rd, u0_wd, u1_wd;
  logic          u0_busy, u1_busy, u0_done, u1_done, u0_ack, u1_ack;
  logic          u0_map, u1_map, u0_to, u1_to, u0_start, u1_start, u0_rw, u1_rw;
  logic [6:0]    u0_addr, u1_addr;

  logic          sel = 1'b0;
  logic [DW-1:0] o_rd, o_wd;
  logic          o_busy, o_done, o_ack, o_map, o_to, o_start, o_rw;
  logic [6:0]    o_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_addr_xlate_table #(.NUM_ENTRIES(NE), .DATA_W(DW), .PASS_UNMAPPED(1'b0), .TIMEOUT_CYCLES(T)) u0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_logical(cfg_logical), .cfg_physical(cfg_physical), .up_start(up_start),
    .up_addr(up_addr), .up_rw(up_rw), .up_wr_data(up_wr_data), .up_rd_data(u0_rd),
    .up_busy(u0_busy), .up_done(u0_done), .up_ack_error(u0_ack), .up_map_error(u0_map),
    .up_timeout(u0_to), .dn_start(u0_start), .dn_addr(u0_addr), .dn_rw(u0_rw),
    .dn_wr_data(u0_wd), .dn_rd_data(dn_rd_data), .dn_busy(dn_busy), .dn_done(dn_done),
    .dn_ack_error(dn_ack_error));

  i2c_addr_xlate_table #(.NUM_ENTRIES(NE), .DATA_W(DW), .PASS_UNMAPPED(1'b1), .TIMEOUT_CYCLES(T)) u1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_logical(cfg_logical), .cfg_physical(cfg_physical), .up_start(up_start),
    .up_addr(up_addr), .up_rw(up_rw), .up_wr_data(up_wr_data), .up_rd_data(u1_rd),
    .up_busy(u1_busy), .up_done(u1_done), .up_ack_error(u1_ack), .up_map_error(u1_map),
    .up_timeout(u1_to), .dn_start(u1_start), .dn_addr(u1_addr), .dn_rw(u1_rw),
    .dn_wr_data(u1_wd), .dn_rd_data(dn_rd_data), .dn_busy(dn_busy), .dn_done(dn_done),
    .dn_ack_error(dn_ack_error));

  assign o_rd    = sel ? u1_rd    : u0_rd;
  assign o_wd    = sel ? u1_wd    : u0_wd;
  assign o_busy  = sel ? u1_busy  : u0_busy;
  assign o_done  = sel ? u1_done  : u0_done;
  assign o_ack   = sel ? u1_ack   : u0_ack;
  assign o_map   = sel ? u1_map   : u0_map;
  assign o_to    = sel ? u1_to    : u0_to;
  assign o_start = sel ? u1_start : u0_start;
  assign o_rw    = sel ? u1_rw    : u0_rw;
  assign o_addr  = sel ? u1_addr  : u0_addr;

  // Reference table
  logic       m_valid [NE];
  logic [6:0] m_log   [NE];
  logic [6:0] m_phys  [NE];

  typedef struct {
    int         start_cyc;
    int         start_cnt;
    int         done_cyc;
    logic [6:0] addr;
    logic [7:0] rd;
    logic       ack;
    logic       map;
    logic       to;
  } exp_t;

  // Observations of the last transaction (cycle 1 = first cycle after accept)
  int         obs_start_cyc, obs_start_cnt, obs_done_cyc;
  logic [6:0] obs_start_addr, obs_addr;
  logic       obs_rw, obs_ack, obs_map, obs_to, obs_busy_bad;
  logic [7:0] obs_wd, obs_rd;
  logic       obs_post_busy, obs_post_done, obs_post_ack;
  logic [7:0] obs_post_rd;

  function automatic void model_clear();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0; m_log[i] = '0; m_phys[i] = '0;
    end
  endfunction

  // Predicts a transaction from the table contents and the timing rules
  function automatic exp_t predict(input logic [6:0] addr, input logic rw, input int busy,
                                   input int delay, input logic [7:0] rdv, input logic ackv,
                                   input bit pass);
    exp_t e;
    bit hit;
    logic [6:0] phys;
    int s;
    hit = 0; phys = '0;
    for (int i = 0; i < NE; i++) begin
      if (!hit && m_valid[i] && m_log[i] == addr) begin
        hit = 1; phys = m_phys[i];
      end
    end
    e.start_cyc = 0; e.start_cnt = 0; e.done_cyc = 1; e.addr = '0;
    e.rd = '0; e.ack = 0; e.map = 0; e.to = 0;
    if (!hit && !pass) begin
      e.map = 1;
    end else begin
      s = busy + 1;
      e.start_cyc = s; e.start_cnt = 1;
      e.addr = hit ? phys : addr;
      if (delay > 0 && s + delay <= T) begin
        e.done_cyc = s + delay + 1;
        e.rd  = rw ? rdv : 8'h00;
        e.ack = ackv;
      end else begin
        e.done_cyc = T + 1;
        e.to = 1; e.ack = 1;
      end
    end
    return e;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; cfg_we = 1'b0; up_start = 1'b0; dn_busy = 1'b0; dn_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic v, input logic [6:0] l, input logic [6:0] p);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v; cfg_logical = l; cfg_physical = p;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_valid[idx] = v; m_log[idx] = l; m_phys[idx] = p;
  endtask

  // Drives one request and plays the downstream master; records observations
  task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                         input int busy, input int delay, input logic [7:0] rdv, input logic ackv,
                         input bit cw_en, input logic [1:0] cw_idx, input logic cw_v,
                         input logic [6:0] cw_l, input logic [6:0] cw_p, input bit spur);
    bit fin;
    fin = 0;
    obs_start_cyc = 0; obs_start_cnt = 0; obs_done_cyc = 0; obs_busy_bad = 0;
    obs_start_addr = '0; obs_addr = '0; obs_rw = 0; obs_wd = '0; obs_rd = '0;
    obs_ack = 0; obs_map = 0; obs_to = 0;
    obs_post_busy = 1; obs_post_done = 1; obs_post_ack = 0; obs_post_rd = '0;
    @(posedge clk); #1;
    up_start = 1'b1; up_addr = addr; up_rw = rw; up_wr_data = wdata;
    cfg_we = cw_en; cfg_idx = cw_idx; cfg_valid = cw_v; cfg_logical = cw_l; cfg_physical = cw_p;
    for (int c = 1; c <= T + 8; c++) begin
      @(posedge clk); #1;
      if (c == 1 && cw_en) begin
        m_valid[cw_idx] = cw_v; m_log[cw_idx] = cw_l; m_phys[cw_idx] = cw_p;
      end
      cfg_we = 1'b0;
      up_start = spur && (c == 2);
      up_addr  = (spur && c == 2) ? 7'h7F : addr;
      dn_busy  = (c <= busy);
      dn_done  = 1'b0;
      dn_ack_error = 1'($urandom);
      dn_rd_data   = 8'($urandom);
      @(negedge clk);
      if (o_start) begin
        obs_start_cnt++;
        if (obs_start_cyc == 0) begin
          obs_start_cyc = c; obs_start_addr = o_addr;
        end
      end
      if (fin) begin
        obs_post_busy = o_busy; obs_post_done = o_done;
        obs_post_ack = o_ack; obs_post_rd = o_rd;
        break;
      end
      if (!o_busy) obs_busy_bad = 1;
      if (o_done) begin
        obs_done_cyc = c; obs_addr = o_addr; obs_rw = o_rw; obs_wd = o_wd;
        obs_rd = o_rd; obs_ack = o_ack; obs_map = o_map; obs_to = o_to;
        fin = 1;
      end else if (delay > 0 && obs_start_cyc != 0 && c == obs_start_cyc + delay) begin
        dn_done = 1'b1; dn_ack_error = ackv; dn_rd_data = rdv;
      end
    end
    up_start = 1'b0; dn_done = 1'b0; dn_busy = 1'b0;
    $display("txn dut%0d addr=%02h rw=%0d start@%0d x%0d done@%0d dn_addr=%02h rd=%02h ack=%0d map=%0d to=%0d",
             sel, addr, rw, obs_start_cyc, obs_start_cnt, obs_done_cyc, obs_addr, obs_rd, obs_ack, obs_map, obs_to);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; up_start = 1'b1; up_addr = 7'h10; cfg_we = 1'b1; dn_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (u0_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", u0_busy); end
    n_checks++; if (u0_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", u0_done); end
    n_checks++; if (u0_start !== 1'b0) begin n_fail++; $display("FAIL reset_dn_start: got %0b expected 0", u0_start); end
    n_checks++; if ({u0_rd, u0_ack, u0_map, u0_to, u0_addr, u0_rw, u0_wd} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got rd=%h ack=%b map=%b to=%b addr=%h rw=%b wd=%h expected all 0",
                         u0_rd, u0_ack, u0_map, u0_to, u0_addr, u0_rw, u0_wd); end
    n_checks++; if ({u1_rd, u1_busy, u1_done, u1_ack, u1_map, u1_to, u1_start, u1_addr, u1_rw, u1_wd} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_u1: got nonzero output, expected all 0"); end
    #1; rst = 1'b0; up_start = 1'b0; cfg_we = 1'b0;
    model_clear();
  endtask

  task automatic test_mapped_write();
    exp_t e;
    cfg_write(2'd0, 1'b1, 7'h10, 7'h20);
    cfg_write(2'd1, 1'b1, 7'h11, 7'h21);
    e = predict(7'h11, 1'b0, 0, 2, 8'h00, 1'b0, 0);
    run_txn(7'h11, 1'b0, 8'hA5, 0, 2, 8'h00, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
    n_checks++; if (obs_start_cyc !== 1) begin n_fail++; $display("FAIL wr_start_cycle: got %0d expected 1", obs_start_cyc); end
    n_checks++; if (obs_start_addr !== 7'h21) begin n_fail++; $display("FAIL wr_dn_addr: got %h expected 21", obs_start_addr); end
    n_checks++; if (obs_wd !== 8'hA5) begin n_fail++; $display("FAIL wr_dn_wr_data: got %h expected a5", obs_wd); end
    n_checks++; if (obs_rw !== 1'b0) begin n_fail++; $display("FAIL wr_dn_rw: got %b expected 0", obs_rw); end
    n_checks++; if (obs_done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected %0d", obs_done_cyc, e.done_cyc); end
    n_checks++; if ({obs_ack, obs_map, obs_to} !== 3'b000) begin n_fail++; $display("FAIL wr_flags: got %b%b%b expected 000", obs_ack, obs_map, obs_to); end
  endtask

  task automatic test_mapped_read();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e = predict(7'h10, 1'b1, 0, 3, 8'h5C, 1'(k), 0);
      run_txn(7'h10, 1'b1, 8'h00, 0, 3, 8'h5C, 1'(k), 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
      n_checks++; if (obs_addr !== 7'h20) begin n_fail++; $display("FAIL rd_dn_addr: got %h expected 20", obs_addr); end
      n_checks++; if (obs_rd !== 8'h5C) begin n_fail++; $display("FAIL rd_data: got %h expected 5c", obs_rd); end
      n_checks++; if (obs_ack !== 1'(k)) begin n_fail++; $display("FAIL rd_ack_error: got %b expected %0d", obs_ack, k); end
      n_checks++; if (obs_done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL rd_done_cycle: got %0d expected %0d", obs_done_cyc, e.done_cyc); end
      n_checks++; if (obs_post_rd !== 8'h5C || obs_post_busy !== 1'b0) begin
        n_fail++; $display("FAIL rd_hold: got rd=%h busy=%b expected rd=5c busy=0", obs_post_rd, obs_post_busy); end
    end
  endtask

  task automatic test_unmapped_reject();
    run_txn(7'h33, 1'b1, 8'h00, 0, 2, 8'h77, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
    n_checks++; if (obs_done_cyc !== 1) begin n_fail++; $display("FAIL rej_done_cycle: got %0d expected 1", obs_done_cyc); end
    n_checks++; if (obs_map !== 1'b1) begin n_fail++; $display("FAIL rej_map_error: got %b expected 1", obs_map); end
    n_checks++; if (obs_start_cnt !== 0) begin n_fail++; $display("FAIL rej_no_launch: got %0d pulses expected 0", obs_start_cnt); end
    n_checks++; if (obs_addr !== 7'h00 || obs_ack !== 1'b0) begin n_fail++; $display("FAIL rej_addr_ack: got addr=%h ack=%b expected 00/0", obs_addr, obs_ack); end
  endtask

  task automatic test_pass_unmapped();
    apply_reset();
    sel = 1'b1;
    run_txn(7'h33, 1'b1, 8'h00, 0, 2, 8'h66, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
    n_checks++; if (obs_start_addr !== 7'h33 || obs_start_cnt !== 1) begin
      n_fail++; $display("FAIL pass_launch: got addr=%h pulses=%0d expected 33/1", obs_start_addr, obs_start_cnt); end
    n_checks++; if (obs_map !== 1'b0 || obs_rd !== 8'h66) begin
      n_fail++; $display("FAIL pass_result: got map=%b rd=%h expected 0/66", obs_map, obs_rd); end
    sel = 1'b0;
  endtask

  task automatic test_priority_same_cycle();
    apply_reset();
    cfg_write(2'd0, 1'b1, 7'h12, 7'h40);
    cfg_write(2'd2, 1'b1, 7'h12, 7'h41);
    run_txn(7'h12, 1'b0, 8'h3C, 0, 1, 8'h00, 1'b0, 1, 2'd0, 1'b0, 7'h12, 7'h40, 0);
    n_checks++; if (obs_start_addr !== 7'h40) begin n_fail++; $display("FAIL prio_same_cycle: got %h expected 40", obs_start_addr); end
    run_txn(7'h12, 1'b0, 8'h3C, 0, 1, 8'h00, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
    n_checks++; if (obs_start_addr !== 7'h41) begin n_fail++; $display("FAIL prio_after_write: got %h expected 41", obs_start_addr); end
  endtask

  task automatic test_busy_gate();
    exp_t e;
    e = predict(7'h12, 1'b1, 5, 2, 8'h9E, 1'b0, 0);
    run_txn(7'h12, 1'b1, 8'h00, 5, 2, 8'h9E, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 1);
    n_checks++; if (obs_start_cyc !== e.start_cyc) begin n_fail++; $display("FAIL busy_start_cycle: got %0d expected %0d", obs_start_cyc, e.start_cyc); end
    n_checks++; if (obs_start_cnt !== 1) begin n_fail++; $display("FAIL busy_single_pulse: got %0d expected 1", obs_start_cnt); end
    n_checks++; if (obs_addr !== 7'h41 || obs_rd !== 8'h9E) begin n_fail++; $display("FAIL busy_ignore_start: got addr=%h rd=%h expected 41/9e", obs_addr, obs_rd); end
    n_checks++; if (obs_busy_bad !== 1'b0) begin n_fail++; $display("FAIL busy_up_busy: got dropout=%b expected 0", obs_busy_bad); end
  endtask

  task automatic test_timeout();
    exp_t e;
    // no completion at all, completion exactly on the expiry cycle, one cycle late
    int delays [3] = '{0, T - 1, T};
    for (int k = 0; k < 3; k++) begin
      e = predict(7'h12, 1'b1, 0, delays[k], 8'hC3, 1'b0, 0);
      run_txn(7'h12, 1'b1, 8'h00, 0, delays[k], 8'hC3, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
      n_checks++; if (obs_done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL tmo_done_cycle[%0d]: got %0d expected %0d", k, obs_done_cyc, e.done_cyc); end
      n_checks++; if ({obs_to, obs_ack, obs_rd} !== {e.to, e.ack, e.rd}) begin
        n_fail++; $display("FAIL tmo_flags[%0d]: got to=%b ack=%b rd=%h expected to=%b ack=%b rd=%h",
                           k, obs_to, obs_ack, obs_rd, e.to, e.ack, e.rd); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    cfg_write(2'd0, 1'b1, 7'h10, 7'h2A);
    @(posedge clk); #1;
    up_start = 1'b1; up_addr = 7'h10; up_rw = 1'b0; up_wr_data = 8'hA5; dn_busy = 1'b0;
    @(posedge clk); #1 up_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (u0_busy !== 1'b1 || u0_addr !== 7'h2A) begin n_fail++; $display("FAIL mid_wait: got busy=%b addr=%h expected 1/2a", u0_busy, u0_addr); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({u0_rd, u0_busy, u0_done, u0_ack, u0_map, u0_to, u0_start, u0_addr, u0_rw, u0_wd} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got busy=%b done=%b start=%b addr=%h wd=%h expected all 0",
                         u0_busy, u0_done, u0_start, u0_addr, u0_wd); end
    model_clear();
    e = predict(7'h10, 1'b1, 0, 2, 8'h00, 1'b0, 0);
    run_txn(7'h10, 1'b1, 8'h00, 0, 2, 8'h00, 1'b0, 0, 2'd0, 1'b0, 7'h0, 7'h0, 0);
    n_checks++; if (obs_map !== e.map || obs_start_cnt !== e.start_cnt) begin
      n_fail++; $display("FAIL mid_table_cleared: got map=%b pulses=%0d expected %b/%0d", obs_map, obs_start_cnt, e.map, e.start_cnt); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [6:0] addr;
    logic       rw, ackv, cw_en, cw_v;
    logic [7:0] wd, rdv;
    logic [1:0] cw_idx;
    logic [6:0] cw_l, cw_p;
    int busy, delay;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom), 1'($urandom_range(0, 3) != 0), 7'h10 + 7'($urandom_range(0, 5)), 7'($urandom));
      addr   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h10 + 7'($urandom_range(0, 5));
      rw     = 1'($urandom);
      wd     = 8'($urandom);
      rdv    = 8'($urandom);
      ackv   = 1'($urandom);
      busy   = $urandom_range(0, 4);
      delay  = $urandom_range(0, 14);
      cw_en  = ($urandom_range(0, 3) == 0);
      cw_idx = 2'($urandom);
      cw_v   = 1'($urandom);
      cw_l   = 7'h10 + 7'($urandom_range(0, 5));
      cw_p   = 7'($urandom);
      e = predict(addr, rw, busy, delay, rdv, ackv, 0);
      run_txn(addr, rw, wd, busy, delay, rdv, ackv, cw_en, cw_idx, cw_v, cw_l, cw_p, 0);
      n_checks++; if (obs_start_cnt !== e.start_cnt || obs_start_cyc !== e.start_cyc) begin
        n_fail++; $display("FAIL rnd_launch[%0d]: got cyc=%0d x%0d expected cyc=%0d x%0d", n, obs_start_cyc, obs_start_cnt, e.start_cyc, e.start_cnt); end
      n_checks++; if (obs_done_cyc !== e.done_cyc) begin
        n_fail++; $display("FAIL rnd_done_cycle[%0d]: got %0d expected %0d", n, obs_done_cyc, e.done_cyc); end
      n_checks++; if (obs_addr !== e.addr || obs_rw !== rw || obs_wd !== wd) begin
        n_fail++; $display("FAIL rnd_dn_fields[%0d]: got addr=%h rw=%b wd=%h expected addr=%h rw=%b wd=%h", n, obs_addr, obs_rw, obs_wd, e.addr, rw, wd); end
      n_checks++; if ({obs_rd, obs_ack, obs_map, obs_to} !== {e.rd, e.ack, e.map, e.to}) begin
        n_fail++; $display("FAIL rnd_result[%0d]: got rd=%h ack=%b map=%b to=%b expected rd=%h ack=%b map=%b to=%b",
                           n, obs_rd, obs_ack, obs_map, obs_to, e.rd, e.ack, e.map, e.to); end
      n_checks++; if (obs_busy_bad !== 1'b0 || obs_post_busy !== 1'b0 || obs_post_done !== 1'b0 ||
                      obs_post_rd !== e.rd || obs_post_ack !== e.ack) begin
        n_fail++; $display("FAIL rnd_handshake[%0d]: got dropout=%b post_busy=%b post_done=%b post_rd=%h post_ack=%b expected 0/0/0/%h/%b",
                           n, obs_busy_bad, obs_post_busy, obs_post_done, obs_post_rd, obs_post_ack, e.rd, e.ack); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    test_reset();
    test_mapped_write();
    test_mapped_read();
    test_unmapped_reject();
    test_pass_unmapped();
    test_priority_same_cycle();
    test_busy_gate();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_addr_xlate_table.md
Name: i2c_addr_xlate_table

Overview:
- Parametrised successor to the fixed 3-entry I2C address translator.
- Sits between an upstream I2C transaction requester and the downstream I2C master.
- Maps 7-bit logical target addresses to physical addresses through a runtime-programmable table of NUM_ENTRIES entries.
- Adds a configurable unmapped-address policy, a downstream-busy launch gate, a transaction timeout and distinct error flags.

Parameters:
- NUM_ENTRIES, 4: number of table entries, 1..16. IDX_W = max(1, clog2(NUM_ENTRIES)).
- DATA_W, 8: write/read data width.
- PASS_UNMAPPED, 0: 1 = forward unmapped addresses unchanged; 0 = reject them with up_map_error.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in LAUNCH+WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  entry index written; indices >= NUM_ENTRIES are ignored.
- cfg_valid  in  1  entry valid bit.
- cfg_logical  in  7  logical address for the entry.
- cfg_physical  in  7  physical address for the entry.
- up_start  in  1  transaction request pulse.
- up_addr  in  7  logical target address.
- up_rw  in  1  1 = read, 0 = write.
- up_wr_data  in  DATA_W  write data.
- up_rd_data  out  DATA_W  read data.
- up_busy  out  1  transaction in progress.
- up_done  out  1  one-cycle completion pulse.
- up_ack_error  out  1  downstream NACK, or timeout.
- up_map_error  out  1  unmapped address rejected.
- up_timeout  out  1  timeout abort.
- dn_start  out  1  one-cycle launch pulse.
- dn_addr  out  7  physical address.
- dn_rw  out  1  read/write to downstream.
- dn_wr_data  out  DATA_W  write data to downstream.
- dn_rd_data  in  DATA_W  downstream read data.
- dn_busy  in  1  downstream master occupied.
- dn_done  in  1  downstream completion pulse.
- dn_ack_error  in  1  downstream NACK, qualified by dn_done.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All table entries become invalid; state = IDLE; timeout counter = 0.
  - All outputs = 0.
  - Reset mid-transaction aborts immediately: no up_done, no dn_start.
- Table writes:
  - cfg_we writes {valid, logical, physical} at cfg_idx on the clock edge.
  - Allowed in any state.
  - Lookup uses table contents before the edge, so a write in the same cycle as an accepted up_start does not affect that transaction.
- Lookup (combinational on up_addr):
  - Hit = any valid entry whose logical field equals up_addr.
  - Multiple hits: the lowest index wins.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - up_start=1 at edge k accepts the request.
  - Latches dn_rw=up_rw and dn_wr_data=up_wr_data.
  - Clears up_map_error, up_timeout and up_ack_error, and zeroes up_rd_data.
  - Hit: dn_addr = physical; go to LAUNCH.
  - Miss with PASS_UNMAPPED=1: dn_addr = up_addr; go to LAUNCH.
  - Miss with PASS_UNMAPPED=0: dn_addr = 0, up_map_error = 1; go directly to DONE. No dn_start is issued.
- LAUNCH:
  - While dn_busy=1: hold in LAUNCH with dn_start=0.
  - When dn_busy=0: dn_start=1 for exactly that one cycle, then go to WAIT.
- WAIT:
  - dn_done=1 at an edge: latch up_rd_data = dn_rd_data (read only; otherwise 0) and up_ack_error = dn_ack_error; go to DONE.
- Timeout (only when TIMEOUT_CYCLES>0):
  - The counter clears on entering LAUNCH and increments every cycle in LAUNCH and WAIT.
  - When TIMEOUT_CYCLES cycles elapse without dn_done: up_timeout = 1, up_ack_error = 1, up_rd_data = 0; go to DONE.
  - If dn_done arrives on the expiry cycle, dn_done wins and no timeout is flagged.
- DONE:
  - up_done = 1 for exactly one cycle, then IDLE.
  - Error flags and up_rd_data stay held until the next accept.
- up_busy = 1 in LAUNCH, WAIT and DONE; 0 in IDLE. up_start outside IDLE is ignored.
- dn_addr, dn_rw and dn_wr_data stay stable from the accept until the next accept.
- Latency, mapped and dn_busy=0: accept at edge k; dn_start high in cycle k+1. dn_done sampled at edge m; up_done high in cycle m+1.
- Latency, rejected unmapped: accept at edge k; up_done high in cycle k+1.
- All outputs are registered or decoded from registered state; no combinational path from up_* inputs to any output.

Test Plan:
- Program idx0 = {1, 0x10, 0x20} and idx1 = {1, 0x11, 0x21}. Write to 0x11 with data 0xA5 -> dn_start one cycle after accept, dn_addr=0x21, dn_wr_data=0xA5, dn_rw=0. Answer dn_done with ack_error=0 -> up_done one cycle later, all error flags 0.
- Read from 0x10 with dn_rd_data=0x5C at dn_done -> up_rd_data=0x5C, up_ack_error=0. Repeat with dn_ack_error=1 -> up_ack_error=1.
- PASS_UNMAPPED=0, read 0x33 -> up_done in cycle k+1, up_map_error=1, dn_start never asserted. With PASS_UNMAPPED=1 -> dn_addr=0x33 launched.
- idx0 and idx2 both map 0x12 (to 0x40 and 0x41) -> dn_addr=0x40. Overwrite idx0 with valid=0 in the same cycle as up_start -> still 0x40; the next transaction gets 0x41.
- dn_busy held high for 5 cycles after accept -> dn_start suppressed, then a single pulse. TIMEOUT_CYCLES=16 with no dn_done -> up_done with up_timeout=1, up_ack_error=1, up_rd_data=0.
- Assert rst during WAIT -> the next cycle has all outputs 0 and state IDLE; a lookup of 0x10 now misses (table cleared).
